// File: rtl/fetch_byte_queue_if.sv
// Fetch-side bundle: decode handshake, redirect and I-cache fill port of the fetch byte queue.
// master = the queue (producer), slave = the environment driving decode/I-cache responses.
interface fetch_byte_queue_if #(
    parameter int LINE_BYTES = 16
);
    logic                      i_stall;
    logic                      i_redirect_valid;
    logic [31:0]               i_redirect_pc;
    logic                      o_icache_req;
    logic [31:0]               o_icache_addr;
    logic                      i_icache_ack;
    logic [8*LINE_BYTES-1:0]   i_icache_data;
    logic [2:0]                i_len_in;
    logic [39:0]               o_instr_out;
    logic [31:0]               o_pc_out;
    logic [2:0]                o_instr_length_out;
    logic                      o_valid_out;

    modport master (
        input  i_stall, i_redirect_valid, i_redirect_pc, i_icache_ack, i_icache_data, i_len_in,
        output o_icache_req, o_icache_addr, o_instr_out, o_pc_out, o_instr_length_out, o_valid_out
    );

    modport slave (
        output i_stall, i_redirect_valid, i_redirect_pc, i_icache_ack, i_icache_data, i_len_in,
        input  o_icache_req, o_icache_addr, o_instr_out, o_pc_out, o_instr_length_out, o_valid_out
    );
endinterface

// File: rtl/fetch_byte_queue.sv
// Instruction byte queue between the I-cache and decode: line fills in at the tail,
// variable-length instructions (1..5 bytes) out at the head.
module fetch_byte_queue #(
    parameter int          LINE_BYTES  = 16,
    parameter int          QUEUE_BYTES = 32,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fetch_byte_queue_if.master    bus
);
    localparam int          OFF_W     = $clog2(LINE_BYTES);
    localparam int          Q_W       = $clog2(QUEUE_BYTES);
    localparam int          OCC_W     = Q_W + 1;
    localparam logic [31:0] LINE_MASK = ~(32'(LINE_BYTES) - 32'd1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [OCC_W-1:0]   r_occ;
    logic [Q_W-1:0]     r_head;
    logic [Q_W-1:0]     r_tail;
    logic [31:0]        r_pc;
    logic [31:0]        r_fill_addr;
    logic [31:0]        r_req_addr;
    logic [OFF_W-1:0]   r_skip;
    logic [7:0]         r_mem [QUEUE_BYTES];

    logic [OCC_W-1:0]   w_len;
    logic [OCC_W-1:0]   w_fill_bytes;
    logic [OCC_W-1:0]   w_free;
    logic               w_valid;
    logic               w_consume;
    logic               w_fill;
    logic [31:0]        w_fill_addr_next;
    logic [QUEUE_BYTES-1:0] w_wr_en;
    logic [7:0]         w_wr_byte [QUEUE_BYTES];

    assign w_len        = OCC_W'(bus.i_len_in);
    assign w_fill_bytes = OCC_W'(LINE_BYTES) - OCC_W'(r_skip);
    assign w_free       = OCC_W'(QUEUE_BYTES) - r_occ;
    assign w_valid      = (r_occ >= w_len) && (bus.i_len_in != 3'd0) && !bus.i_redirect_valid;
    assign w_consume    = w_valid && !bus.i_stall;
    // A response that coincides with a redirect belongs to the old path and is dropped.
    assign w_fill       = (r_state == S_REQ) && bus.i_icache_ack && !bus.i_redirect_valid;

    always_comb begin
        w_fill_addr_next = r_fill_addr;
        if (bus.i_redirect_valid)
            w_fill_addr_next = bus.i_redirect_pc & LINE_MASK;
        else if (w_fill)
            w_fill_addr_next = r_fill_addr + 32'(LINE_BYTES);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_free >= OCC_W'(LINE_BYTES)) w_state_next = S_REQ;
            S_REQ: begin
                if (bus.i_icache_ack)          w_state_next = S_IDLE;
                else if (bus.i_redirect_valid) w_state_next = S_DROP;
            end
            S_DROP: if (bus.i_icache_ack) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_occ       <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_pc        <= RESET_PC;
            r_fill_addr <= RESET_PC & LINE_MASK;
            r_req_addr  <= RESET_PC & LINE_MASK;
            r_skip      <= RESET_PC[OFF_W-1:0];
        end else begin
            r_state     <= w_state_next;
            r_fill_addr <= w_fill_addr_next;
            // The request address is latched at launch so a dropped request keeps its stale line.
            if (r_state == S_IDLE && w_state_next == S_REQ)
                r_req_addr <= w_fill_addr_next;
            if (bus.i_redirect_valid) begin
                r_occ  <= '0;
                r_head <= '0;
                r_tail <= '0;
                r_pc   <= bus.i_redirect_pc;
                r_skip <= bus.i_redirect_pc[OFF_W-1:0];
            end else begin
                r_occ <= r_occ + (w_fill ? w_fill_bytes : '0) - (w_consume ? w_len : '0);
                if (w_consume) begin
                    r_head <= r_head + w_len[Q_W-1:0];
                    r_pc   <= r_pc + 32'(bus.i_len_in);
                end
                if (w_fill) begin
                    r_tail <= r_tail + w_fill_bytes[Q_W-1:0];
                    r_skip <= '0;
                end
            end
        end
    end

    // Each queue slot picks its byte from the line by its distance from the tail.
    for (genvar gi = 0; gi < QUEUE_BYTES; gi++) begin : g_wr
        logic [Q_W-1:0]   w_rel;
        logic [OFF_W-1:0] w_src;
        assign w_rel         = Q_W'(gi) - r_tail;
        assign w_src         = r_skip + w_rel[OFF_W-1:0];
        assign w_wr_en[gi]   = w_fill && (OCC_W'(w_rel) < w_fill_bytes);
        assign w_wr_byte[gi] = bus.i_icache_data[8*w_src +: 8];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < QUEUE_BYTES; i++) begin
            if (w_wr_en[i]) r_mem[i] <= w_wr_byte[i];
        end
    end

    for (genvar gi = 0; gi < 5; gi++) begin : g_rd
        logic [Q_W-1:0] w_rd_idx;
        assign w_rd_idx                  = r_head + Q_W'(gi);
        assign bus.o_instr_out[8*gi +: 8] = r_mem[w_rd_idx];
    end

    assign bus.o_icache_req       = (r_state != S_IDLE);
    assign bus.o_icache_addr      = r_req_addr;
    assign bus.o_pc_out           = r_pc;
    assign bus.o_instr_length_out = bus.i_len_in;
    assign bus.o_valid_out        = w_valid;
endmodule

// File: tb/tb_fetch_byte_queue.sv
// Directed vectors for fetch_byte_queue: fill, consume, stall, wrap, redirect/drop, async reset.
module tb_fetch_byte_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_byte_queue_if #(.LINE_BYTES(16)) bus ();

    fetch_byte_queue #(.LINE_BYTES(16), .QUEUE_BYTES(32), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic         stall;
        logic         redir;
        logic [31:0]  rpc;
        logic         ack;
        logic [127:0] dline;
        logic [2:0]   len;
        logic         e_req;
        logic [31:0]  e_addr;
        logic         e_valid;
        logic [31:0]  e_pc;
        logic [39:0]  e_instr;
        logic [39:0]  e_mask;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;
    localparam logic [39:0] FULL = 40'hFF_FFFF_FFFF;

    // Line contents are a function of the line address so every byte is recognisable.
    function automatic logic [127:0] line_of(input logic [31:0] addr);
        logic [127:0] l;
        for (int k = 0; k < 16; k++) l[8*k +: 8] = (addr[7:0] ^ addr[15:8]) + 8'(k);
        return l;
    endfunction

    task automatic add(input logic stall, input logic redir, input logic [31:0] rpc,
                       input logic ack, input logic [31:0] daddr, input logic [2:0] len,
                       input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                       input logic [31:0] e_pc, input logic [39:0] e_instr, input logic [39:0] e_mask);
        vec_t v;
        v.stall = stall; v.redir = redir; v.rpc = rpc; v.ack = ack;
        v.dline = ack ? line_of(daddr) : 128'h0; v.len = len;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        v.e_instr = e_instr; v.e_mask = e_mask;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("check %s ok: %h", name, act);
        end
    endtask

    task automatic drive(input logic stall, input logic redir, input logic [31:0] rpc,
                         input logic ack, input logic [127:0] dline, input logic [2:0] len);
        bus.i_stall = stall; bus.i_redirect_valid = redir; bus.i_redirect_pc = rpc;
        bus.i_icache_ack = ack; bus.i_icache_data = dline; bus.i_len_in = len;
    endtask

    initial begin
        logic ok;
        drive(0, 0, 0, 0, 128'h0, 3'd2);

        // Line 0 fill, then len-2 consumption with a back-to-back fill of line 0x10.
        add(0,0,0, 1,32'h0,   3'd2, 1,32'h0,  0,32'h0,  40'h0,          40'h0);
        add(0,0,0, 0,32'h0,   3'd2, 0,32'h0,  1,32'h0,  40'h0100,       40'hFFFF);
        add(0,0,0, 0,32'h0,   3'd2, 1,32'h10, 1,32'h2,  40'h0302,       40'hFFFF);
        add(0,0,0, 1,32'h10,  3'd2, 1,32'h10, 1,32'h4,  40'h0504,       40'hFFFF);
        // Stall holds pc; queue too full for another request.
        add(1,0,0, 0,32'h0,   3'd5, 0,32'h0,  1,32'h6,  40'h0A09080706, FULL);
        add(1,0,0, 0,32'h0,   3'd5, 0,32'h0,  1,32'h6,  40'h0A09080706, FULL);
        add(0,0,0, 0,32'h0,   3'd5, 0,32'h0,  1,32'h6,  40'h0A09080706, FULL);
        add(0,0,0, 0,32'h0,   3'd5, 0,32'h0,  1,32'hB,  40'h0F0E0D0C0B, FULL);
        add(0,0,0, 0,32'h0,   3'd5, 0,32'h0,  1,32'h10, 40'h1413121110, FULL);
        add(0,0,0, 0,32'h0,   3'd5, 1,32'h20, 1,32'h15, 40'h1918171615, FULL);
        add(0,0,0, 0,32'h0,   3'd5, 1,32'h20, 1,32'h1A, 40'h1E1D1C1B1A, FULL);
        // Too few bytes for len 5; fill arrives and the instruction spans the wrap.
        add(0,0,0, 0,32'h0,   3'd5, 1,32'h20, 0,32'h1F, 40'h1F,         40'hFF);
        add(0,0,0, 1,32'h20,  3'd5, 1,32'h20, 0,32'h1F, 40'h1F,         40'hFF);
        add(0,0,0, 0,32'h0,   3'd5, 0,32'h0,  1,32'h1F, 40'h232221201F, FULL);
        add(1,0,0, 0,32'h0,   3'd1, 0,32'h0,  1,32'h24, 40'h2524,       40'hFFFF);
        add(0,0,0, 0,32'h0,   3'd1, 1,32'h30, 1,32'h24, 40'h24,         40'hFF);
        // Redirect during a pending request, second redirect while dropping, stale ack discarded.
        add(0,1,32'h2000, 0,32'h0,  3'd1, 1,32'h30, 0,32'h25,   40'h25, 40'hFF);
        add(0,0,0,        0,32'h0,  3'd1, 1,32'h30, 0,32'h2000, 40'h0,  40'h0);
        add(0,1,32'h1007, 0,32'h0,  3'd1, 1,32'h30, 0,32'h2000, 40'h0,  40'h0);
        add(0,0,0,        1,32'h30, 3'd1, 1,32'h30, 0,32'h1007, 40'h0,  40'h0);
        add(0,0,0,        0,32'h0,  3'd1, 0,32'h0,  0,32'h1007, 40'h0,  40'h0);
        add(0,0,0,        0,32'h0,  3'd1, 1,32'h1000, 0,32'h1007, 40'h0, 40'h0);
        add(0,0,0,        1,32'h1000, 3'd1, 1,32'h1000, 0,32'h1007, 40'h0, 40'h0);
        // Unaligned target: only bytes 7..15 of the line enter the queue.
        add(0,0,0, 0,32'h0, 3'd5, 0,32'h0,    1,32'h1007, 40'h1B1A191817, FULL);
        add(0,0,0, 0,32'h0, 3'd5, 1,32'h1010, 0,32'h100C, 40'h1D1C,       40'hFFFF);
        add(0,0,0, 0,32'h0, 3'd4, 1,32'h1010, 1,32'h100C, 40'h1F1E1D1C,   40'hFFFFFFFF);
        // Redirect and ack in the same cycle: nothing written, back to IDLE.
        add(0,1,32'h40, 1,32'h1010, 3'd1, 1,32'h1010, 0,32'h1010, 40'h0, 40'h0);
        add(0,0,0,      0,32'h0,    3'd1, 0,32'h0,    0,32'h40,   40'h0, 40'h0);
        add(0,0,0,      0,32'h0,    3'd0, 1,32'h40,   0,32'h40,   40'h0, 40'h0);
        add(0,0,0,      1,32'h40,   3'd0, 1,32'h40,   0,32'h40,   40'h0, 40'h0);
        add(0,0,0,      0,32'h0,    3'd0, 0,32'h0,    0,32'h40,   40'h4140,   40'hFFFF);
        add(0,0,0,      0,32'h0,    3'd3, 1,32'h50,   1,32'h40,   40'h424140, 40'hFFFFFF);

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        chk("reset_req",   40'(bus.o_icache_req), 40'h0);
        chk("reset_valid", 40'(bus.o_valid_out),  40'h0);
        chk("reset_pc",    40'(bus.o_pc_out),     40'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].ack, vecs[i].dline, vecs[i].len);
            #1;
            ok = (bus.o_icache_req === vecs[i].e_req) &&
                 (!vecs[i].e_req || bus.o_icache_addr === vecs[i].e_addr) &&
                 (bus.o_valid_out === vecs[i].e_valid) &&
                 (bus.o_pc_out === vecs[i].e_pc) &&
                 (bus.o_instr_length_out === vecs[i].len) &&
                 ((bus.o_instr_out & vecs[i].e_mask) === (vecs[i].e_instr & vecs[i].e_mask));
            n_vec++;
            if (!ok) begin
                n_bad++;
                $display("FAIL vec%0d: got req=%b addr=%h valid=%b pc=%h len=%0d instr=%h; expected req=%b addr=%h valid=%b pc=%h len=%0d instr=%h mask=%h",
                         i, bus.o_icache_req, bus.o_icache_addr, bus.o_valid_out, bus.o_pc_out,
                         bus.o_instr_length_out, bus.o_instr_out, vecs[i].e_req, vecs[i].e_addr,
                         vecs[i].e_valid, vecs[i].e_pc, vecs[i].len, vecs[i].e_instr, vecs[i].e_mask);
            end else begin
                $display("vec%0d ok: req=%b valid=%b pc=%h instr=%h", i, bus.o_icache_req,
                         bus.o_valid_out, bus.o_pc_out, bus.o_instr_out);
            end
        end

        // Async reset while a request is outstanding drops it without waiting for a clock.
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req",   40'(bus.o_icache_req), 40'h0);
        chk("async_rst_valid", 40'(bus.o_valid_out),  40'h0);
        chk("async_rst_pc",    40'(bus.o_pc_out),     40'h0);

        // A late ack in IDLE must not write anything.
        @(negedge clk);
        drive(0, 0, 0, 1, line_of(32'h0), 3'd1);
        rst_n = 1'b1;
        @(negedge clk);
        drive(0, 0, 0, 0, 128'h0, 3'd1);
        #1;
        chk("late_ack_req",   40'(bus.o_icache_req),  40'h1);
        chk("late_ack_addr",  40'(bus.o_icache_addr), 40'h0);
        chk("late_ack_valid", 40'(bus.o_valid_out),   40'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
